agc_gain_ctrl: RTL and testbench
================================

// Module: agc_gain_ctrl
// PURPOSE
//  Frame-based gain controller for the AGC datapath. It tracks the peak |sample| over each frame
//  and computes target gain = TARGET/peak with a sequential restoring divider. The applied Q8.8 gain
//  slews toward that target with separate attack and release steps. gain_q88 drives the datapath
//  multiplier: out = (in * gain_q88)[15:8].
// PARAMETERS
//  FRAME_LOG2  10       log2 of valid samples per frame; legal range 5..12
//  TARGET      16'h3F00 dividend, Q8.8 (target output peak 63)
//  GAIN_MAX    16'h1400 upper clamp on target gain (20.0)
//  GAIN_INIT   16'h0100 reset value of gain and target (unity)
//  STEP_UP     16'h0010 maximum gain increase per valid sample (release)
//  STEP_DN     16'h0100 maximum gain decrease per valid sample (attack)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  clk_enable   in   1   global enable; when low, all state holds
//  in_valid     in   1   in_sample is a new sample this cycle
//  in_sample    in   8   signed input sample
//  freeze       in   1   hold gain_q88 (ramp paused); peak tracking and divide continue
//  gain_q88     out  16  applied gain, unsigned Q8.8, registered
//  target_gain  out  16  latest clamped divider result, registered
//  frame_end    out  1   1-cycle pulse after the last sample of a frame is accepted
//  gain_update  out  1   1-cycle pulse when target_gain is loaded
//  busy         out  1   divider active
//  ce_out       out  1   = clk_enable
// BEHAVIOUR
//  - rst=1 at a clock edge: gain_q88=target_gain=GAIN_INIT; frame_end=gain_update=busy=0;
//    sample count=0; running peak=0; FSM=ACC. rst overrides clk_enable and aborts any divide,
//    with no gain_update.
//  - All updates require clk_enable=1. A sample is accepted when in_valid=1 and clk_enable=1.
//  - abs: |x| is formed as an 8-bit unsigned value; |-128| = 128 (no wrap).
//    running_peak = max(running_peak, |x|) on each accepted sample.
//  - Frame: the counter wraps at 2^FRAME_LOG2 accepted samples. On the last sample:
//    - peak_snap <= max(running_peak, |x|); running_peak <= 0.
//    - frame_end=1 for the next cycle. FSM ACC->DIV, busy=1.
//  - The FRAME_LOG2>=5 minimum guarantees the divide completes before the next frame ends, so
//    frames never overlap.
//  - FSM ACC: idle; peak tracking runs.
//  - FSM DIV, peak_snap==0: 1 enabled cycle, then target_gain<=GAIN_MAX.
//  - FSM DIV, otherwise: 16-bit restoring divide TARGET/peak_snap, one quotient bit per enabled
//    cycle (MSB first), 16 cycles. The load edge is the 17th enabled cycle.
//  - Load: target_gain <= min(quotient, GAIN_MAX). gain_update=1 for one cycle, busy=0, FSM->ACC.
//  - Latency: gain_update asserts 17 enabled cycles after frame_end (1 cycle if peak=0).
//    Each clk_enable-low cycle adds 1.
//  - Peak tracking of the next frame continues during DIV.
//  - Ramp: on each accepted sample with freeze=0:
//    - gain<target: gain <= min(gain+STEP_UP, target).
//    - gain>target: gain <= max(gain-STEP_DN, target).
//    - Compute in 17 bits; no overflow or underflow wrap.
//  - Ramp compares against the registered target_gain, so a target loaded in cycle N affects
//    samples from N+1 on.
// TESTING
//  1 rst=1 for 2 cycles -> gain_q88=0x0100, target_gain=0x0100, busy=0, no pulses for 40 idle cycles.
//  2 FRAME_LOG2=5, 32 samples of +63 -> frame_end; gain_update 17 cycles later; target_gain=0x0100;
//    gain unchanged.
//  3 32 samples of -128 -> target_gain=0x007E. The next valid sample gives gain 0x0100->0x007E
//    (step clamped to target).
//  4 32 samples of 0 -> gain_update 1 cycle after frame_end, target=0x1400. Gain rises 0x10 per
//    valid sample and reaches 0x1400 after 304 samples.
//  5 peak=1 -> quotient 0x3F00 clamped to 0x1400. With freeze=1 for 10 samples, gain holds; it
//    resumes stepping after freeze drops.
//  6 rst at DIV cycle 8 -> busy=0 next cycle, no gain_update, all reset values.
//    Separately, clk_enable=0 for 5 cycles mid-DIV -> gain_update arrives 22 cycles after frame_end.

Source files
------------

// File: rtl/agc_gain_ctrl.sv
// Frame-based AGC gain controller: per-frame peak detect, restoring divide TARGET/peak,
// and an attack/release slew of the applied Q8.8 gain toward the clamped quotient.
module agc_gain_ctrl #(
    parameter int          FRAME_LOG2 = 10,
    parameter logic [15:0] TARGET     = 16'h3F00,
    parameter logic [15:0] GAIN_MAX   = 16'h1400,
    parameter logic [15:0] GAIN_INIT  = 16'h0100,
    parameter logic [15:0] STEP_UP    = 16'h0010,
    parameter logic [15:0] STEP_DN    = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic        in_valid,
    input  logic [7:0]  in_sample,
    input  logic        freeze,
    output logic [15:0] gain_q88,
    output logic [15:0] target_gain,
    output logic        frame_end,
    output logic        gain_update,
    output logic        busy,
    output logic        ce_out
);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_DIV = 1'b1
    } state_t;

    // Magnitude of a two's-complement byte; -128 maps to 128 without wrapping.
    function automatic logic [7:0] abs8(input logic [7:0] x);
        abs8 = x[7] ? (~x + 8'd1) : x;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        max8 = (a > b) ? a : b;
    endfunction

    // One slew step toward t, computed in 17 bits so neither direction can wrap.
    function automatic logic [15:0] ramp_next(input logic [15:0] g, input logic [15:0] t);
        logic [16:0] up;
        logic [16:0] dn;
        up = {1'b0, g} + {1'b0, STEP_UP};
        dn = {1'b0, g} - {1'b0, STEP_DN};
        if (g < t) begin
            ramp_next = (up > {1'b0, t}) ? t : up[15:0];
        end else if (g > t) begin
            ramp_next = (dn[16] || (dn[15:0] < t)) ? t : dn[15:0];
        end else begin
            ramp_next = g;
        end
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [FRAME_LOG2-1:0]   cnt_r;
    logic [7:0]              running_peak_r;
    logic [7:0]              peak_snap_r;
    logic [15:0]             dq_r;
    logic [7:0]              rem_r;
    logic [4:0]              bit_cnt_r;
    logic [15:0]             gain_r;
    logic [15:0]             target_r;
    logic                    frame_end_r;
    logic                    gain_update_r;
    logic                    busy_r;

    logic                    accept_s;
    logic                    last_s;
    logic [7:0]              peak_new_s;
    logic                    div_step_s;
    logic                    load_s;
    logic [8:0]              trial_s;
    logic                    qbit_s;
    logic [7:0]              rem_nx_s;
    logic [15:0]             q_clamped_s;

    assign accept_s   = clk_enable && in_valid;
    assign last_s     = accept_s && (cnt_r == {FRAME_LOG2{1'b1}});
    assign peak_new_s = max8(running_peak_r, abs8(in_sample));

    // Restoring-divide datapath: dq_r shifts the dividend out and the quotient in.
    always_comb begin
        trial_s     = {rem_r, dq_r[15]};
        qbit_s      = 1'b0;
        rem_nx_s    = trial_s[7:0];
        q_clamped_s = GAIN_MAX;
        if (trial_s >= {1'b0, peak_snap_r}) begin
            qbit_s   = 1'b1;
            rem_nx_s = trial_s[7:0] - peak_snap_r;
        end else begin
            qbit_s   = 1'b0;
            rem_nx_s = trial_s[7:0];
        end
        if ((peak_snap_r == 8'd0) || (dq_r > GAIN_MAX)) begin
            q_clamped_s = GAIN_MAX;
        end else begin
            q_clamped_s = dq_r;
        end
    end

    // Next-state logic; a zero peak skips the divide and loads the clamp value directly.
    always_comb begin
        state_nx_s = state_r;
        div_step_s = 1'b0;
        load_s     = 1'b0;
        case (state_r)
            ST_ACC: begin
                if (last_s) begin
                    state_nx_s = ST_DIV;
                end else begin
                    state_nx_s = ST_ACC;
                end
            end
            ST_DIV: begin
                if (!clk_enable) begin
                    state_nx_s = ST_DIV;
                end else if ((peak_snap_r == 8'd0) || (bit_cnt_r == 5'd16)) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_ACC;
                end else begin
                    div_step_s = 1'b1;
                    state_nx_s = ST_DIV;
                end
            end
            default: begin
                state_nx_s = ST_ACC;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Frame counter, peak tracking, divider, target load and gain slew.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r          <= {FRAME_LOG2{1'b0}};
            running_peak_r <= 8'd0;
            peak_snap_r    <= 8'd0;
            dq_r           <= 16'd0;
            rem_r          <= 8'd0;
            bit_cnt_r      <= 5'd0;
            gain_r         <= GAIN_INIT;
            target_r       <= GAIN_INIT;
            frame_end_r    <= 1'b0;
            gain_update_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else if (clk_enable) begin
            frame_end_r   <= last_s;
            gain_update_r <= load_s;
            if (accept_s) begin
                cnt_r <= cnt_r + {{(FRAME_LOG2-1){1'b0}}, 1'b1};
                if (last_s) begin
                    peak_snap_r    <= peak_new_s;
                    running_peak_r <= 8'd0;
                end else begin
                    running_peak_r <= peak_new_s;
                end
            end
            if (last_s) begin
                dq_r      <= TARGET;
                rem_r     <= 8'd0;
                bit_cnt_r <= 5'd0;
                busy_r    <= 1'b1;
            end else if (div_step_s) begin
                dq_r      <= {dq_r[14:0], qbit_s};
                rem_r     <= rem_nx_s;
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
            if (load_s) begin
                target_r <= q_clamped_s;
                busy_r   <= 1'b0;
            end
            if (accept_s && !freeze) begin
                gain_r <= ramp_next(gain_r, target_r);
            end
        end
    end

    assign gain_q88    = gain_r;
    assign target_gain = target_r;
    assign frame_end   = frame_end_r;
    assign gain_update = gain_update_r;
    assign busy        = busy_r;
    assign ce_out      = clk_enable;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Scoreboard bench for agc_gain_ctrl with 32-sample frames: stimulus pushes the expected
// target and latency per frame; a negedge monitor pops and checks on every gain_update.
module tb_agc_gain_ctrl;
    localparam logic [15:0] GMAX = 16'h1400;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_enable;
    logic        in_valid;
    logic [7:0]  in_sample;
    logic        freeze;
    logic [15:0] gain_q88;
    logic [15:0] target_gain;
    logic        frame_end;
    logic        gain_update;
    logic        busy;
    logic        ce_out;

    always #5 clk = ~clk;

    agc_gain_ctrl #(.FRAME_LOG2(5)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .in_valid(in_valid),
        .in_sample(in_sample), .freeze(freeze), .gain_q88(gain_q88),
        .target_gain(target_gain), .frame_end(frame_end), .gain_update(gain_update),
        .busy(busy), .ce_out(ce_out)
    );

    typedef struct {
        logic [15:0] tgt;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          fe_cyc = 0;
    int          fe_count = 0;
    int          upd_count = 0;
    int          pos = 0;
    int          mpeak = 0;
    int          extra_lat = 0;
    bit          suppress = 1'b0;

    // Monitor: every gain_update must match the oldest expectation.
    always @(negedge clk) begin
        cyc++;
        if (frame_end) begin
            fe_cyc = cyc;
            fe_count++;
        end
        if (gain_update) begin
            upd_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update target_gain=%h required=none", target_gain);
            end else begin
                mon_e = exp_q.pop_front();
                if (target_gain !== mon_e.tgt) begin
                    errors++;
                    $display("FAIL target_gain actual=%h required=%h", target_gain, mon_e.tgt);
                end
                checks++;
                if ((cyc - fe_cyc) != mon_e.lat) begin
                    errors++;
                    $display("FAIL update_latency actual=%0d required=%0d", cyc - fe_cyc, mon_e.lat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_tgt(input int p);
        int q;
        if (p == 0) return GMAX;
        q = 16128 / p;
        return (q > 5120) ? GMAX : 16'(q);
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        pos = 0;
        mpeak = 0;
    endtask

    task automatic send(input logic [7:0] v, input int n, input logic fz);
        int a;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_sample = v;
            freeze    = fz;
            step(1);
            a = $signed(v);
            if (a < 0) a = -a;
            if (a > mpeak) mpeak = a;
            pos++;
            if (pos == 32) begin
                if (!suppress) begin
                    e.tgt = model_tgt(mpeak);
                    e.lat = ((mpeak == 0) ? 1 : 17) + extra_lat;
                    exp_q.push_back(e);
                end
                pos = 0;
                mpeak = 0;
            end
        end
        in_valid = 1'b0;
        freeze   = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0) && (k < 100)) begin
            step(1);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        step(2);
    endtask

    initial begin
        int fe0;
        int up0;
        rst = 1'b1; clk_enable = 1'b1; in_valid = 1'b0; in_sample = 8'd0; freeze = 1'b0;
        // 1: reset values and quiet idle
        do_reset();
        chk("rst_gain", gain_q88, 16'h0100);
        chk("rst_target", target_gain, 16'h0100);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_frame_end", {15'd0, frame_end}, 16'd0);
        fe0 = fe_count;
        up0 = upd_count;
        step(40);
        chk("idle_frame_end", 16'(fe_count - fe0), 16'd0);
        chk("idle_update", 16'(upd_count - up0), 16'd0);

        // 2: peak 63 -> unity target, gain unchanged
        send(8'd63, 32, 1'b0);
        chk("busy_after_frame", {15'd0, busy}, 16'd1);
        drain();
        chk("t2_target", target_gain, 16'h0100);
        chk("t2_gain", gain_q88, 16'h0100);

        // 3: peak 128 -> 0x007E, attack step clamps to target
        send(8'h80, 32, 1'b0);
        drain();
        chk("t3_target", target_gain, 16'h007E);
        send(8'd0, 1, 1'b0);
        chk("t3_gain", gain_q88, 16'h007E);

        // 4: zero peak -> GAIN_MAX after 1 cycle, release ramp to 0x1400 in 304 samples
        do_reset();
        send(8'd0, 32, 1'b0);
        drain();
        chk("t4_target", target_gain, GMAX);
        for (int k = 1; k <= 305; k++) begin
            send(8'd0, 1, 1'b0);
            chk("t4_ramp", gain_q88, (k >= 304) ? GMAX : 16'(16'h0100 + 16 * k));
        end
        drain();

        // 5: peak 1 -> clamped; freeze holds the gain
        do_reset();
        send(8'd1, 32, 1'b0);
        drain();
        chk("t5_target", target_gain, GMAX);
        send(8'd0, 10, 1'b1);
        chk("t5_frozen", gain_q88, 16'h0100);
        send(8'd0, 1, 1'b0);
        chk("t5_resume", gain_q88, 16'h0110);

        // 6a: reset in DIV cycle 8 aborts with no update
        do_reset();
        suppress = 1'b1;
        send(8'd5, 32, 1'b0);
        suppress = 1'b0;
        step(7);
        chk("t6_busy_mid", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        step(1);
        chk("t6_busy_rst", {15'd0, busy}, 16'd0);
        chk("t6_gain_rst", gain_q88, 16'h0100);
        chk("t6_target_rst", target_gain, 16'h0100);
        rst = 1'b0;
        pos = 0;
        mpeak = 0;
        up0 = upd_count;
        step(30);
        chk("t6_no_update", 16'(upd_count - up0), 16'd0);

        // 6b: 5 disabled cycles mid-DIV stretch latency to 22
        extra_lat = 5;
        send(8'd5, 32, 1'b0);
        extra_lat = 0;
        step(3);
        clk_enable = 1'b0;
        step(5);
        chk("t6_ce_out", {15'd0, ce_out}, 16'd0);
        clk_enable = 1'b1;
        drain();
        chk("t6_target", target_gain, 16'h0C99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
